// File: rtl/btn_event_scheduler.sv
// Collects debounced button levels and turns them into one ordered stream of
// SHORT / LONG / REPEAT key events. The lowest button index has priority.
module btn_event_scheduler #(
  parameter int N_BTN       = 5,
  parameter int LONG_TIME   = 100_000_000,
  parameter int REPEAT_TIME = 20_000_000,
  parameter int ID_W        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [N_BTN-1:0] i_btn_stable,
  input  logic             i_clear,
  input  logic             i_evt_ready,
  output logic             o_evt_valid,
  output logic [ID_W-1:0]  o_evt_id,
  output logic [1:0]       o_evt_type,
  output logic [N_BTN-1:0] o_held,
  output logic             o_overrun
);

  localparam int MAX_TIME = (LONG_TIME > REPEAT_TIME) ? LONG_TIME : REPEAT_TIME;
  localparam int CNT_W    = $clog2(MAX_TIME);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } btn_state_t;

  typedef enum logic [1:0] {
    EVT_SHORT  = 2'd0,
    EVT_LONG   = 2'd1,
    EVT_REPEAT = 2'd2
  } evt_type_t;

  logic [N_BTN-1:0] emit_valid;
  evt_type_t        emit_type [N_BTN];

  logic [N_BTN-1:0] pend_valid;
  evt_type_t        pend_type [N_BTN];

  logic             slot_free;
  logic             any_pend;
  logic [N_BTN-1:0] grant;
  logic [ID_W-1:0]  sel_id;
  evt_type_t        sel_type;

  // One timing FSM per button; its event decision is registered so the
  // pending stage sees a clean single-cycle pulse.
  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             prev;
    logic             cur;
    logic             emit_v;
    evt_type_t        emit_t;

    assign cur = i_btn_stable[g];

    // prev resets high so a button held through reset must be released
    // and pressed again before it counts.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        prev   <= 1'b1;
        emit_v <= 1'b0;
        emit_t <= EVT_SHORT;
      end else begin
        prev   <= cur;
        emit_v <= 1'b0;
        case (state)
          ST_IDLE: begin
            cnt <= '0;
            if (cur && !prev) begin
              state <= ST_PRESSED;
            end
          end
          ST_PRESSED: begin
            if (!cur) begin
              emit_v <= 1'b1;
              emit_t <= EVT_SHORT;
              state  <= ST_IDLE;
              cnt    <= '0;
            end else if (cnt == LONG_LAST) begin
              emit_v <= 1'b1;
              emit_t <= EVT_LONG;
              state  <= ST_REPEAT;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (!cur) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (cnt == REPEAT_LAST) begin
              emit_v <= 1'b1;
              emit_t <= EVT_REPEAT;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign emit_valid[g] = emit_v;
    assign emit_type[g]  = emit_t;
    assign o_held[g]     = (state != ST_IDLE);
  end

  // Lowest set pending bit wins; grant is only issued when the output
  // register can take a new beat.
  assign slot_free = !o_evt_valid || i_evt_ready;
  assign any_pend  = |pend_valid;
  assign grant     = slot_free ? (pend_valid & ~(pend_valid - N_BTN'(1))) : '0;

  always_comb begin
    sel_id   = '0;
    sel_type = pend_type[0];
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend_valid[i]) begin
        sel_id   = ID_W'(i);
        sel_type = pend_type[i];
      end
    end
  end

  // A new event always lands in its slot; it is an overrun only if the old
  // content was still waiting and is not leaving this cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pend_valid <= '0;
      o_overrun  <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        pend_type[i] <= EVT_SHORT;
      end
    end else if (i_clear) begin
      pend_valid <= '0;
      o_overrun  <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (emit_valid[i]) begin
          pend_valid[i] <= 1'b1;
          pend_type[i]  <= emit_type[i];
          if (pend_valid[i] && !grant[i]) begin
            o_overrun <= 1'b1;
          end
        end else if (grant[i]) begin
          pend_valid[i] <= 1'b0;
        end
      end
    end
  end

  // id/type only move when a new beat is loaded, so they stay stable under
  // backpressure and keep their last value once the port goes idle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_evt_valid <= 1'b0;
      o_evt_id    <= '0;
      o_evt_type  <= 2'd0;
    end else if (i_clear) begin
      o_evt_valid <= 1'b0;
    end else if (slot_free) begin
      if (any_pend) begin
        o_evt_valid <= 1'b1;
        o_evt_id    <= sel_id;
        o_evt_type  <= sel_type;
      end else begin
        o_evt_valid <= 1'b0;
      end
    end
  end

endmodule
